alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 8, max cycles in BUSY before a timeout.
REQ-002 soc_clk  in  1  single clock, all state on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 reqN_valid (N=0,1)  in  1  requester N holds an operation.
REQ-005 reqN_dat1, reqN_dat2  in  32  operands.
REQ-006 reqN_instr  in  5  ALU instruction code (0-15 valid).
REQ-007 reqN_ready  out  1  operation accepted this cycle.
REQ-008 rspN_valid  out  1  one-cycle response strobe.
REQ-009 rspN_out  out  32  result.
REQ-010 rspN_flags  out  4  {err, overflow, con_met, zero}.
REQ-011 alu_dat_ready  out  1  drives ALU dat_ready.
REQ-012 alu_dat1, alu_dat2  out  32  operands to ALU.
REQ-013 alu_instr  out  5  Instruction_to_ALU.
REQ-014 alu_ready, alu_overflow, alu_con_met, alu_zero  in  1 each  ALU status.
REQ-015 alu_out  in  32  ALU result.

Function
REQ-016 FSM states are IDLE, BUSY, DRAIN.
REQ-017 In IDLE, exactly one reqN_ready is driven combinationally high for the granted valid requester; both are low when neither requester is valid.
REQ-018 Grant is round-robin: a lone valid requester wins; when both are valid, the requester not granted last wins.
REQ-019 On accept (valid and ready at a rising edge), the arbiter registers operands, instr and requester ID, and moves to BUSY.
REQ-020 alu_dat_ready is high only in BUSY; alu_dat1, alu_dat2 and alu_instr hold the latched values from accept until IDLE.
REQ-021 In BUSY, sampling alu_ready=1 captures alu_out and the flags (err=0), pulses rspN_valid for one cycle on the next edge, and moves to DRAIN.
REQ-022 With the nominal 4-cycle ALU, rspN_valid rises on the 5th rising edge after the accept edge.
REQ-023 In DRAIN, the arbiter waits until alu_ready is sampled 0, then returns to IDLE; no accept occurs in BUSY or DRAIN.
REQ-024 Timeout: after TIMEOUT_CYCLES consecutive BUSY cycles without alu_ready, the arbiter responds with rsp_out=0 and flags=4'b1000, then moves to DRAIN.
REQ-025 If reqN_instr >= 16 at accept, the ALU is not issued; rspN_valid pulses on the next edge with out=0 and flags=4'b1000, and the FSM stays in IDLE.
REQ-026 Only the requester whose ID was latched sees rsp_valid; the other rsp_valid stays 0.
REQ-027 Responses have no backpressure.
REQ-028 Requesters hold valid and all fields stable until ready is high.
REQ-029 The BUSY cycle counter saturates and clears on every entry to BUSY.

Reset
REQ-030 On reset assertion, and mid-operation: state goes to IDLE, and all outputs, latched operands, counters and rsp registers go to 0.
REQ-031 After reset, the round-robin pointer favours requester 0.
REQ-032 After reset deasserts, the first accept can occur on the first rising edge.

Structure
REQ-033 Package alu_pkg holds the instruction code constants (0-16), the FSM state enum, the flag bit positions, and RSP_ERR_FLAGS=4'b1000.
REQ-034 The two-requester round-robin grant logic is one sub-module, rr_arbiter2 (req[1:0], advance -> grant[1:0]).

Verification
REQ-035 Scenario: req0 ADD (instr 6), dat1=5, dat2=7 -> rsp0_valid on the 5th edge after accept, rsp0_out=12, flags=0000.
REQ-036 Scenario: req0 and req1 both valid from reset, req1 BEQ (instr 0) 3,3 -> req0 served first, then req1 with con_met=1; rsp1_flags=0010.
REQ-037 Scenario: req1 SUB (instr 7), dat1=9, dat2=9 -> rsp1_out=0, flags=0001.
REQ-038 Scenario: alu_ready tied 0 -> after 8 BUSY cycles, rsp0_valid with out=0, flags=1000, then IDLE.
REQ-039 Scenario: instr=20 -> no alu_dat_ready pulse; rsp on the next edge with flags=1000.
REQ-040 Scenario: reset asserted during BUSY -> alu_dat_ready drops asynchronously, no rsp_valid, and the next request is accepted normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: instruction codes,
// FSM states, response flag layout and the error flag pattern.
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int INSTR_W = 5;
    localparam int FLAGS_W = 4;

    localparam logic [INSTR_W-1:0] INSTR_BEQ     = 5'd0;
    localparam logic [INSTR_W-1:0] INSTR_BNE     = 5'd1;
    localparam logic [INSTR_W-1:0] INSTR_BLT     = 5'd2;
    localparam logic [INSTR_W-1:0] INSTR_BGE     = 5'd3;
    localparam logic [INSTR_W-1:0] INSTR_BLTU    = 5'd4;
    localparam logic [INSTR_W-1:0] INSTR_BGEU    = 5'd5;
    localparam logic [INSTR_W-1:0] INSTR_ADD     = 5'd6;
    localparam logic [INSTR_W-1:0] INSTR_SUB     = 5'd7;
    localparam logic [INSTR_W-1:0] INSTR_AND     = 5'd8;
    localparam logic [INSTR_W-1:0] INSTR_OR      = 5'd9;
    localparam logic [INSTR_W-1:0] INSTR_XOR     = 5'd10;
    localparam logic [INSTR_W-1:0] INSTR_SLL     = 5'd11;
    localparam logic [INSTR_W-1:0] INSTR_SRL     = 5'd12;
    localparam logic [INSTR_W-1:0] INSTR_SRA     = 5'd13;
    localparam logic [INSTR_W-1:0] INSTR_SLT     = 5'd14;
    localparam logic [INSTR_W-1:0] INSTR_SLTU    = 5'd15;
    localparam logic [INSTR_W-1:0] INSTR_INVALID = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_CON_MET  = 1;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_ERR      = 3;

    localparam logic [FLAGS_W-1:0] RSP_ERR_FLAGS = 4'b1000;

    // Codes at or above INSTR_INVALID are never issued to the ALU.
    function automatic logic instr_is_valid(input logic [INSTR_W-1:0] instr);
        return instr < INSTR_INVALID;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins, and on contention the
// requester that was not granted last wins. advance commits the current grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    // NOTE: combinational blocks assign every output a default first, so no
    // path through the case can leave a value unassigned and infer a latch.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (advance && (grant != 2'b00)) begin
            last_d = grant[1];
        end
    end

    // Resetting "last" to requester 1 makes requester 0 the favoured one.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared multi-cycle ALU, returning each
// result (or an error response on timeout / bad instruction) to its owner.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                soc_clk,
    input  logic                reset,

    input  logic                req0_valid,
    input  logic [DATA_W-1:0]   req0_dat1,
    input  logic [DATA_W-1:0]   req0_dat2,
    input  logic [INSTR_W-1:0]  req0_instr,
    output logic                req0_ready,

    input  logic                req1_valid,
    input  logic [DATA_W-1:0]   req1_dat1,
    input  logic [DATA_W-1:0]   req1_dat2,
    input  logic [INSTR_W-1:0]  req1_instr,
    output logic                req1_ready,

    output logic                rsp0_valid,
    output logic [DATA_W-1:0]   rsp0_out,
    output logic [FLAGS_W-1:0]  rsp0_flags,
    output logic                rsp1_valid,
    output logic [DATA_W-1:0]   rsp1_out,
    output logic [FLAGS_W-1:0]  rsp1_flags,

    output logic                alu_dat_ready,
    output logic [DATA_W-1:0]   alu_dat1,
    output logic [DATA_W-1:0]   alu_dat2,
    output logic [INSTR_W-1:0]  alu_instr,
    input  logic                alu_ready,
    input  logic                alu_overflow,
    input  logic                alu_con_met,
    input  logic                alu_zero,
    input  logic [DATA_W-1:0]   alu_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    dat1_q, dat1_d;
    logic [DATA_W-1:0]    dat2_q, dat2_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 id_q, id_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_out_q, rsp_out_d;
    logic [FLAGS_W-1:0]   rsp_flags_q, rsp_flags_d;

    logic [1:0]           grant;
    logic [1:0]           ready;
    logic                 accept;
    logic                 sel_id;
    logic [DATA_W-1:0]    sel_dat1;
    logic [DATA_W-1:0]    sel_dat2;
    logic [INSTR_W-1:0]   sel_instr;

    rr_arbiter2 u_rr (
        .clk     (soc_clk),
        .rst     (reset),
        .req     ({req1_valid, req0_valid}),
        .advance (accept),
        .grant   (grant)
    );

    // Grants are only offered in IDLE and never while reset is held.
    assign ready     = (state_q == IDLE && !reset) ? grant : 2'b00;
    assign accept    = |ready;
    assign sel_id    = ready[1];
    assign sel_dat1  = sel_id ? req1_dat1  : req0_dat1;
    assign sel_dat2  = sel_id ? req1_dat2  : req0_dat2;
    assign sel_instr = sel_id ? req1_instr : req0_instr;

    always_comb begin
        state_d     = state_q;
        dat1_d      = dat1_q;
        dat2_d      = dat2_q;
        instr_d     = instr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 2'b00;
        rsp_out_d   = rsp_out_q;
        rsp_flags_d = rsp_flags_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    dat1_d  = sel_dat1;
                    dat2_d  = sel_dat2;
                    instr_d = sel_instr;
                    id_d    = sel_id;
                    if (instr_is_valid(sel_instr)) begin
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        rsp_valid_d[sel_id] = 1'b1;
                        rsp_out_d           = '0;
                        rsp_flags_d         = RSP_ERR_FLAGS;
                    end
                end
            end

            BUSY: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (alu_ready) begin
                    rsp_valid_d[id_q]            = 1'b1;
                    rsp_out_d                    = alu_out;
                    rsp_flags_d                  = '0;
                    rsp_flags_d[FLAG_OVERFLOW]   = alu_overflow;
                    rsp_flags_d[FLAG_CON_MET]    = alu_con_met;
                    rsp_flags_d[FLAG_ZERO]       = alu_zero;
                    state_d                      = DRAIN;
                end else if (cnt_q >= CNT_LAST) begin
                    // This is the last allowed cycle without a result.
                    rsp_valid_d[id_q] = 1'b1;
                    rsp_out_d         = '0;
                    rsp_flags_d       = RSP_ERR_FLAGS;
                    state_d           = DRAIN;
                end
            end

            DRAIN: begin
                if (!alu_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dat1_q      <= '0;
            dat2_q      <= '0;
            instr_q     <= '0;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 2'b00;
            rsp_out_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            dat1_q      <= dat1_d;
            dat2_q      <= dat2_d;
            instr_q     <= instr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_out_q   <= rsp_out_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign req0_ready    = ready[0];
    assign req1_ready    = ready[1];
    assign rsp0_valid    = rsp_valid_q[0];
    assign rsp1_valid    = rsp_valid_q[1];
    assign rsp0_out      = rsp_out_q;
    assign rsp1_out      = rsp_out_q;
    assign rsp0_flags    = rsp_flags_q;
    assign rsp1_flags    = rsp_flags_q;
    assign alu_dat_ready = (state_q == BUSY);
    assign alu_dat1      = dat1_q;
    assign alu_dat2      = dat2_q;
    assign alu_instr     = instr_q;

endmodule
